// File: rtl/fp32_normalize_round_if.sv
// Handshake and data bundle for the fp32 normalize/round stage.
// The master modport is the producer/consumer side; the slave modport is the stage itself.
interface fp32_normalize_round_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [27:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_flags;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/fp32_normalize_round.sv
// Normalize (one bit per cycle), round-to-nearest-even and pack a binary32 result.
// One operation in flight; flush-to-zero on underflow, saturate to infinity on overflow.
module fp32_normalize_round #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fp32_normalize_round_if.slave  bus
);
    localparam int unsigned MantW  = FRAC_W + 5;  // carry + hidden + frac + G/R/S
    localparam int unsigned SigW   = FRAC_W + 1;  // hidden + frac
    localparam int unsigned ResW   = 1 + EXP_W + FRAC_W;
    localparam int unsigned ExpMax = (1 << EXP_W) - 1;

    typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

    state_e            state_q, state_d;
    logic              sign_q, sign_d;
    logic [9:0]        exp_q, exp_d;
    logic [MantW-1:0]  mant_q, mant_d;
    logic [ResW-1:0]   result_q, result_d;
    logic [2:0]        flags_q, flags_d;

    logic              guard, round_bit, sticky, round_up, inexact;
    logic [SigW:0]     sig_rnd;
    logic [10:0]       exp_rnd;

    // Rounding arithmetic on the current (already normalized) mantissa
    always_comb begin
        guard     = mant_q[2];
        round_bit = mant_q[1];
        sticky    = mant_q[0];
        round_up  = guard & (round_bit | sticky | mant_q[3]);
        inexact   = guard | round_bit | sticky;
        sig_rnd   = {1'b0, mant_q[MantW-2:3]} + (SigW+1)'(round_up);
        // Extra bit keeps the overflow compare honest for exponents near the top of 10 bits
        exp_rnd   = {1'b0, exp_q} + 11'(sig_rnd[SigW]);
    end

    // Next-state logic for the control FSM and datapath registers
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        result_d = result_q;
        flags_d  = flags_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    sign_d  = bus.in_sign;
                    exp_d   = bus.in_exp;
                    mant_d  = bus.in_mant;
                    state_d = StNorm;
                end
            end
            StNorm: begin
                if (mant_q == '0) begin
                    result_d = {sign_q, {(ResW-1){1'b0}}};
                    flags_d  = 3'b000;
                    state_d  = StDone;
                end else if (exp_q == 10'd0) begin
                    // Zero exponent with a live mantissa would be denormal: flush
                    result_d = {sign_q, {(ResW-1){1'b0}}};
                    flags_d  = 3'b011;
                    state_d  = StDone;
                end else if (mant_q[MantW-1]) begin
                    // Carry out: shift right, folding the dropped bits into sticky
                    mant_d  = {1'b0, mant_q[MantW-1:2], mant_q[1] | mant_q[0]};
                    exp_d   = exp_q + 10'd1;
                    state_d = StRound;
                end else if (mant_q[MantW-2]) begin
                    state_d = StRound;
                end else begin
                    mant_d = {mant_q[MantW-2:0], 1'b0};
                    exp_d  = exp_q - 10'd1;
                    if (exp_q == 10'd1) begin
                        result_d = {sign_q, {(ResW-1){1'b0}}};
                        flags_d  = 3'b011;
                        state_d  = StDone;
                    end
                end
            end
            StRound: begin
                if (exp_rnd >= 11'(ExpMax)) begin
                    result_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    flags_d  = 3'b101;
                end else begin
                    result_d = {sign_q, exp_rnd[EXP_W-1:0], sig_rnd[FRAC_W-1:0]};
                    flags_d  = {2'b00, inexact};
                end
                state_d = StDone;
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    // Handshake outputs decode directly from the registered state
    always_comb begin
        bus.in_ready   = (state_q == StIdle);
        bus.out_valid  = (state_q == StDone);
        bus.out_result = result_q;
        bus.out_flags  = flags_q;
    end
endmodule
